uart_tx: RTL and testbench
==========================

# uart_tx

UART transmit path: a TX FIFO with a 1-entry holding-register mode, a baud-tick generator and a serialising frame state machine. It sits directly downstream of the UART register block. It consumes THR writes and the line/FIFO/divisor/mode control fields, drives the serial `txd_out` line, and returns the THRE/TEMT status bits for the LMSR read path. It runs entirely in the APB clock domain.

## Interface
- `FIFO_DEPTH`, 16: TX FIFO entries; power of two, ≥2.
- `apb_clk_in` input 1: clock.
- `apb_rstn_in` input 1: reset. Asynchronous, active-low. Clock is `apb_clk_in`.
- `thr_wr_in` input 1: one-cycle THR write strobe from the register block.
- `thr_in` input 8: THR data, sampled when `thr_wr_in`=1.
- `wls_in` input 2: word length; 0→5, 1→6, 2→7, 3→8 data bits.
- `stb_in` input 1: 0→1 stop bit; 1→2 stop bits, or 1.5 stop bits when `wls_in`=0.
- `pen_in`, `eps_in`, `sp_in` input 1 each: parity enable, even-parity select, stick parity.
- `bc_in` input 1: break control; forces `txd_out`=0.
- `fifoen_in` input 1: 1→FIFO mode, 0→1-entry holding register.
- `txclr_in` input 1: one-cycle FIFO clear pulse.
- `dlr_in` input 16: baud divisor.
- `osm_in` input 1: oversample mode; 0→16×, 1→13×.
- `utrst_in` input 1: transmitter enable; 0 holds the transmitter in reset.
- `txd_out` output 1: serial line; idle high.
- `thre_out` output 1: FIFO or holding register empty.
- `temt_out` output 1: `thre_out` and the shifter is idle.
- `tx_level_out` output $clog2(FIFO_DEPTH)+1: FIFO occupancy.

## Operation
- Reset values: `txd_out`=1, `thre_out`=1, `temt_out`=1, `tx_level_out`=0. FSM is IDLE and the baud counter is 0.
- Storage capacity is FIFO_DEPTH when `fifoen_in`=1, otherwise 1.
- A write to full storage is dropped; contents are unchanged.
- Toggling `fifoen_in` clears the storage.
- `txclr_in` empties the storage only; a frame in progress completes.
- `utrst_in`=0 forces the FSM to IDLE, `txd_out` to 1, clears the storage and zeroes the baud counter. Writes are dropped while it is 0.
- Baud generator:
  - Effective divisor is `max(dlr_in,1)`; one tick is issued every divisor clocks.
  - A bit lasts OS ticks, with OS=16 (`osm_in`=0) or 13 (`osm_in`=1).
  - A 1.5-stop bit lasts 24 or 20 ticks respectively.
  - The divisor value is re-read at each counter reload, so a mid-frame change takes effect at the next tick.
- FSM states: IDLE → START → DATA → [PARITY] → STOP → IDLE, or directly to START when storage is non-empty at the end of STOP.
  - IDLE: storage non-empty and `utrst_in`=1 → pop, load the shifter, restart the baud counter, go to START.
  - START: `txd`=0 for one bit.
  - DATA: N bits, LSB first. N is latched from `wls_in` at load.
  - PARITY: present only when `pen_in`=1.
  - STOP: `txd`=1 for the stop duration.
  - `wls_in`, `stb_in`, `pen_in`, `eps_in` and `sp_in` are latched at load and held for the whole frame.
- Parity bit:
  - `sp`=0: XOR of the N data bits, inverted when `eps`=0 (odd parity).
  - `sp`=1: the bit is `~eps`.
- Break: `txd_out`=0 whenever `bc_in`=1. The FSM keeps running underneath.

## Timing
- `txd_out` is registered.
- A write at edge N while IDLE and empty:
  - `tx_level_out`=1 after N.
  - Pop and load at N+1.
  - `txd_out`=0 after N+1.
  - `thre_out`=1 after N+1.
- Each bit lasts exactly divisor×OS clocks.
- Reference frame: 8N1 at `dlr_in`=1, OS=16 is 160 clocks from the falling start edge to the end of the stop bit.
- `temt_out` rises the cycle after the last stop-bit clock, if the storage is empty.
- Back-to-back frames have no idle gap: the next start bit follows the stop bit directly.
- Simultaneous write and pop when full: both are performed and the level is unchanged.
- `txclr_in` together with a write: the clear wins and the write is dropped.
- `utrst_in` deasserted mid-frame: `txd_out`=1 on the next cycle.
- Async reset mid-frame: all outputs return to their reset values immediately.

## Structure
- `uart_pkg` holds:
  - FSM state encoding (one-hot, 5 states).
  - OS16/OS13 constants and the 1.5-stop tick counts.
  - The word-length decode function.
  - Register offsets, shared with the register block.
- Sub-module `uart_tx_fifo` contains:
  - Synchronous FIFO of FIFO_DEPTH×8.
  - Capacity select (1 or FIFO_DEPTH).
  - Clear input.
  - Level, full and empty outputs.
- The top level holds the baud counter, the shifter and the FSM.

## Test plan
- `dlr_in`=1, `osm_in`=0, 8N1, write 0x55 → `txd_out` = 0×16, then 1,0,1,0,1,0,1,0 at 16 clocks each, then 1×16. `temt_out` rises 160 clocks after the start edge.
- 7E2 (`wls`=2, `pen`=1, `eps`=1, `stb`=1), write 0x03 → 7 data bits, parity 0, two stop bits; frame = 11 bits.
- `wls`=0, `stb`=1, `osm_in`=1, `dlr_in`=2, write 0x1F → 5 data bits of 26 clocks each; stop = 40 clocks.
- `fifoen_in`=1, 17 back-to-back writes of 0x00..0x10 while the first frame is active → first byte already popped; `tx_level_out`=16 after the writes; all 17 bytes sent with no idle gap, in order.
- `fifoen_in`=0, two writes 0xA1 and 0xB2 while 0xC3 is shifting → 0xA1 held, 0xB2 dropped; `thre_out`=0 until 0xA1 is loaded.
- Mid-frame `utrst_in`=0 for 3 cycles, plus `bc_in`=1 during a later frame → `txd_out`=1 the next cycle with level 0; `txd_out`=0 for the whole break, and the FSM completes the frame on schedule.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM encoding, oversampling constants,
// word-length decode and the register map used by the register block.
package uart_pkg;

    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00001,
        ST_START  = 5'b00010,
        ST_DATA   = 5'b00100,
        ST_PARITY = 5'b01000,
        ST_STOP   = 5'b10000
    } tx_state_t;

    localparam int OS16        = 16;
    localparam int OS13        = 13;
    localparam int STOP15_OS16 = 24;
    localparam int STOP15_OS13 = 20;

    localparam logic [7:0] REG_RBR_THR = 8'h00;
    localparam logic [7:0] REG_IER     = 8'h04;
    localparam logic [7:0] REG_IIR_FCR = 8'h08;
    localparam logic [7:0] REG_LCR     = 8'h0C;
    localparam logic [7:0] REG_LSR     = 8'h14;
    localparam logic [7:0] REG_DLR     = 8'h20;

    function automatic logic [3:0] wls_to_bits(input logic [1:0] wls);
        return 4'd5 + {2'b00, wls};
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Control/status bundle between the UART register block (master) and the
// transmit path (slave).
interface uart_tx_if #(
    parameter int FIFO_DEPTH = 16
) ();
    logic                          thr_wr_in;
    logic [7:0]                    thr_in;
    logic [1:0]                    wls_in;
    logic                          stb_in;
    logic                          pen_in;
    logic                          eps_in;
    logic                          sp_in;
    logic                          bc_in;
    logic                          fifoen_in;
    logic                          txclr_in;
    logic [15:0]                   dlr_in;
    logic                          osm_in;
    logic                          utrst_in;
    logic                          thre_out;
    logic                          temt_out;
    logic [$clog2(FIFO_DEPTH):0]   tx_level_out;

    modport master (
        output thr_wr_in, thr_in, wls_in, stb_in, pen_in, eps_in, sp_in, bc_in,
               fifoen_in, txclr_in, dlr_in, osm_in, utrst_in,
        input  thre_out, temt_out, tx_level_out
    );

    modport slave (
        input  thr_wr_in, thr_in, wls_in, stb_in, pen_in, eps_in, sp_in, bc_in,
               fifoen_in, txclr_in, dlr_in, osm_in, utrst_in,
        output thre_out, temt_out, tx_level_out
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// TX byte FIFO with first-word fall-through read; capacity is either the full
// depth or a single holding register.
module uart_tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                      apb_clk_in,
    input  logic                      apb_rstn_in,
    input  logic                      i_clr,
    input  logic                      i_fifoen,
    input  logic                      i_wr,
    input  logic [7:0]                i_wdata,
    input  logic                      i_rd,
    output logic [7:0]                o_rdata,
    output logic [$clog2(DEPTH):0]    o_level,
    output logic                      o_full,
    output logic                      o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic [AW:0]   w_cap;
    logic          w_do_wr;
    logic          w_do_rd;

    assign w_cap   = i_fifoen ? (AW+1)'(DEPTH) : (AW+1)'(1);
    assign o_full  = (r_level >= w_cap);
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_rdata = r_mem[r_rd_ptr];

    // A pop frees a slot in the same cycle, so a write to full storage is kept then.
    assign w_do_rd = i_rd && !o_empty && !i_clr;
    assign w_do_wr = i_wr && !i_clr && (!o_full || w_do_rd);

    always_ff @(posedge apb_clk_in) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
        if (!apb_rstn_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end
endmodule

// File: rtl/uart_tx.sv
// UART transmitter: TX storage, baud tick generator and the frame serialiser
// driving a registered txd_out line.
module uart_tx
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic     apb_clk_in,
    input  logic     apb_rstn_in,
    uart_tx_if.slave bus,
    output logic     txd_out
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    tx_state_t r_state;
    tx_state_t w_state_next;

    logic          r_fifoen_d;
    logic          w_clr;
    logic          w_wr;
    logic          w_load;
    logic          w_empty;
    logic          w_full;
    logic [7:0]    w_rdata;
    logic [LW-1:0] w_level;

    logic [15:0]   r_baud_cnt;
    logic [15:0]   w_div;
    logic          w_tick;
    logic [5:0]    r_os_cnt;
    logic [5:0]    w_os;
    logic [5:0]    w_stop_len;
    logic [5:0]    w_bit_len;
    logic          w_bit_end;

    logic [7:0]    r_shift;
    logic [7:0]    w_shift_next;
    logic [2:0]    r_bit_cnt;
    logic [3:0]    r_nbits;
    logic [1:0]    r_wls;
    logic          r_stb;
    logic          r_pen;
    logic          r_parity;
    logic [3:0]    w_nbits_ld;
    logic [7:0]    w_mask;
    logic          w_xor;
    logic          w_parity;
    logic          w_last_data;
    logic          r_txd;
    logic          w_txd_next;

    // Storage is flushed on an explicit clear, a mode change or transmitter reset.
    assign w_clr = bus.txclr_in || (bus.fifoen_in != r_fifoen_d) || !bus.utrst_in;
    assign w_wr  = bus.thr_wr_in && bus.utrst_in && (!w_full || w_load);

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .apb_clk_in  (apb_clk_in),
        .apb_rstn_in (apb_rstn_in),
        .i_clr       (w_clr),
        .i_fifoen    (bus.fifoen_in),
        .i_wr        (w_wr),
        .i_wdata     (bus.thr_in),
        .i_rd        (w_load),
        .o_rdata     (w_rdata),
        .o_level     (w_level),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    assign w_div       = (bus.dlr_in == 16'd0) ? 16'd1 : bus.dlr_in;
    assign w_tick      = (r_state != ST_IDLE) && (r_baud_cnt == 16'd0);
    assign w_os        = bus.osm_in ? 6'(OS13) : 6'(OS16);
    assign w_stop_len  = !r_stb ? w_os :
                         (r_wls == 2'd0) ? (bus.osm_in ? 6'(STOP15_OS13) : 6'(STOP15_OS16)) :
                         (w_os << 1);
    assign w_bit_len   = (r_state == ST_STOP) ? w_stop_len : w_os;
    assign w_bit_end   = w_tick && (r_os_cnt >= w_bit_len - 6'd1);
    assign w_last_data = (r_bit_cnt == 3'(r_nbits - 4'd1));

    assign w_nbits_ld  = wls_to_bits(bus.wls_in);
    assign w_mask      = 8'hFF >> (4'd8 - w_nbits_ld);
    assign w_xor       = ^(w_rdata & w_mask);
    assign w_parity    = bus.sp_in ? !bus.eps_in : (bus.eps_in ? w_xor : !w_xor);

    always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
        if (!apb_rstn_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        if (!bus.utrst_in) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        w_load       = 1'b1;
                        w_state_next = ST_START;
                    end
                end
                ST_START: if (w_bit_end) w_state_next = ST_DATA;
                ST_DATA: begin
                    if (w_bit_end && w_last_data) begin
                        w_state_next = r_pen ? ST_PARITY : ST_STOP;
                    end
                end
                ST_PARITY: if (w_bit_end) w_state_next = ST_STOP;
                ST_STOP: begin
                    if (w_bit_end) begin
                        if (!w_empty) begin
                            w_load       = 1'b1;
                            w_state_next = ST_START;
                        end else begin
                            w_state_next = ST_IDLE;
                        end
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_shift_next = r_shift;
        if (w_load) begin
            w_shift_next = w_rdata;
        end else if ((r_state == ST_DATA) && w_bit_end) begin
            w_shift_next = {1'b0, r_shift[7:1]};
        end
    end

    // The line is driven from the next state so the register lands in step with it.
    always_comb begin
        w_txd_next = 1'b1;
        case (w_state_next)
            ST_START:  w_txd_next = 1'b0;
            ST_DATA:   w_txd_next = w_shift_next[0];
            ST_PARITY: w_txd_next = r_parity;
            default:   w_txd_next = 1'b1;
        endcase
        if (bus.bc_in) begin
            w_txd_next = 1'b0;
        end
    end

    always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
        if (!apb_rstn_in) begin
            r_txd      <= 1'b1;
            r_fifoen_d <= 1'b0;
            r_baud_cnt <= 16'd0;
            r_os_cnt   <= 6'd0;
            r_shift    <= 8'd0;
            r_bit_cnt  <= 3'd0;
            r_nbits    <= 4'd8;
            r_wls      <= 2'd3;
            r_stb      <= 1'b0;
            r_pen      <= 1'b0;
            r_parity   <= 1'b0;
        end else begin
            r_txd      <= w_txd_next;
            r_fifoen_d <= bus.fifoen_in;
            r_shift    <= w_shift_next;

            if (!bus.utrst_in || (w_state_next == ST_IDLE)) begin
                r_baud_cnt <= 16'd0;
            end else if (w_load || (r_baud_cnt == 16'd0)) begin
                r_baud_cnt <= w_div - 16'd1;
            end else begin
                r_baud_cnt <= r_baud_cnt - 16'd1;
            end

            if (!bus.utrst_in || w_load) begin
                r_os_cnt <= 6'd0;
            end else if (w_tick) begin
                r_os_cnt <= w_bit_end ? 6'd0 : r_os_cnt + 6'd1;
            end

            if (w_load) begin
                r_bit_cnt <= 3'd0;
                r_nbits   <= w_nbits_ld;
                r_wls     <= bus.wls_in;
                r_stb     <= bus.stb_in;
                r_pen     <= bus.pen_in;
                r_parity  <= w_parity;
            end else if ((r_state == ST_DATA) && w_bit_end) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
        end
    end

    assign txd_out          = r_txd;
    assign bus.thre_out     = w_empty;
    assign bus.temt_out     = w_empty && (r_state == ST_IDLE);
    assign bus.tx_level_out = w_level;
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frame formats, FIFO/holding modes, clear,
// transmitter reset, break and asynchronous reset.
module tb_uart_tx;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic txd;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    uart_tx_if #(.FIFO_DEPTH(16)) u_if ();

    uart_tx #(.FIFO_DEPTH(16)) dut (
        .apb_clk_in  (clk),
        .apb_rstn_in (rstn),
        .bus         (u_if),
        .txd_out     (txd)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks the first and last clock of every bit; skip>0 means the caller is
    // already positioned at that clock index of the frame.
    task automatic rx_frame(input logic [7:0] d, input int nb, input int par, input int bitc,
                            input int stopc, input int budget, input int skip, input string tag);
        int   pos;
        int   s;
        int   dur;
        int   nbits;
        int   i;
        logic expv;
        pos = skip;
        if (skip == 0) begin
            i = 0;
            while (i < budget && txd !== 1'b0) begin
                @(negedge clk);
                i++;
            end
            chk($sformatf("%s start", tag), {31'd0, txd}, 32'd0);
            if (txd !== 1'b0) return;
        end
        nbits = nb + ((par >= 0) ? 3 : 2);
        s = 0;
        for (int j = 0; j < nbits; j++) begin
            dur = (j == nbits - 1) ? stopc : bitc;
            if (j == 0) expv = 1'b0;
            else if (j <= nb) expv = d[j-1];
            else if (par >= 0 && j == nb + 1) expv = par[0];
            else expv = 1'b1;
            if (s >= skip) begin
                while (pos < s) begin @(negedge clk); pos++; end
                chk($sformatf("%s bit%0d first", tag, j), {31'd0, txd}, {31'd0, expv});
            end
            if (s + dur - 1 >= skip) begin
                while (pos < s + dur - 1) begin @(negedge clk); pos++; end
                chk($sformatf("%s bit%0d last", tag, j), {31'd0, txd}, {31'd0, expv});
            end
            s += dur;
        end
        $display("[TB] %s: frame %02h checked", tag, d);
    endtask

    initial begin
        u_if.thr_wr_in = 1'b0;
        u_if.thr_in    = 8'h00;
        u_if.wls_in    = 2'd3;
        u_if.stb_in    = 1'b0;
        u_if.pen_in    = 1'b0;
        u_if.eps_in    = 1'b0;
        u_if.sp_in     = 1'b0;
        u_if.bc_in     = 1'b0;
        u_if.fifoen_in = 1'b1;
        u_if.txclr_in  = 1'b0;
        u_if.dlr_in    = 16'd1;
        u_if.osm_in    = 1'b0;
        u_if.utrst_in  = 1'b1;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst txd", {31'd0, txd}, 32'd1);
        chk("rst thre", {31'd0, u_if.thre_out}, 32'd1);
        chk("rst temt", {31'd0, u_if.temt_out}, 32'd1);
        chk("rst level", {27'd0, u_if.tx_level_out}, 32'd0);
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle txd", {31'd0, txd}, 32'd1);

        // 8N1, 0x55, exact first-write latency and temt timing
        u_if.thr_in = 8'h55; u_if.thr_wr_in = 1'b1;
        @(negedge clk);
        u_if.thr_wr_in = 1'b0;
        chk("t1 level after wr", {27'd0, u_if.tx_level_out}, 32'd1);
        chk("t1 thre after wr", {31'd0, u_if.thre_out}, 32'd0);
        chk("t1 txd after wr", {31'd0, txd}, 32'd1);
        @(negedge clk);
        chk("t1 thre after load", {31'd0, u_if.thre_out}, 32'd1);
        chk("t1 level after load", {27'd0, u_if.tx_level_out}, 32'd0);
        rx_frame(8'h55, 8, -1, 16, 16, 1, 0, "t1 8N1");
        chk("t1 temt in stop", {31'd0, u_if.temt_out}, 32'd0);
        @(negedge clk);
        chk("t1 temt at 160", {31'd0, u_if.temt_out}, 32'd1);

        // 7E2, 0x03: parity 0, 32-clock stop
        u_if.wls_in = 2'd2; u_if.pen_in = 1'b1; u_if.eps_in = 1'b1; u_if.stb_in = 1'b1;
        u_if.thr_in = 8'h03; u_if.thr_wr_in = 1'b1;
        @(negedge clk);
        u_if.thr_wr_in = 1'b0;
        rx_frame(8'h03, 7, 0, 16, 32, 4, 0, "t2 7E2");
        @(negedge clk);
        chk("t2 temt", {31'd0, u_if.temt_out}, 32'd1);

        // 5N1.5, OS13, divisor 2, 0x1F
        u_if.wls_in = 2'd0; u_if.pen_in = 1'b0; u_if.eps_in = 1'b0; u_if.stb_in = 1'b1;
        u_if.osm_in = 1'b1; u_if.dlr_in = 16'd2;
        u_if.thr_in = 8'h1F; u_if.thr_wr_in = 1'b1;
        @(negedge clk);
        u_if.thr_wr_in = 1'b0;
        rx_frame(8'h1F, 5, -1, 26, 40, 4, 0, "t3 5N1.5");
        @(negedge clk);
        chk("t3 temt", {31'd0, u_if.temt_out}, 32'd1);

        // FIFO burst: 17 writes, a dropped write when full, a write with pop when full
        u_if.wls_in = 2'd3; u_if.stb_in = 1'b0; u_if.osm_in = 1'b0; u_if.dlr_in = 16'd1;
        for (int i = 0; i < 18; i++) begin
            u_if.thr_in = (i == 17) ? 8'h99 : 8'(i);
            u_if.thr_wr_in = 1'b1;
            @(negedge clk);
        end
        u_if.thr_wr_in = 1'b0;
        chk("t4 level full", {27'd0, u_if.tx_level_out}, 32'd16);
        rx_frame(8'h00, 8, -1, 16, 16, 1, 16, "t4 fifo");
        u_if.thr_in = 8'h11; u_if.thr_wr_in = 1'b1;
        @(negedge clk);
        u_if.thr_wr_in = 1'b0;
        chk("t4 level wr+pop", {27'd0, u_if.tx_level_out}, 32'd16);
        rx_frame(8'h01, 8, -1, 16, 16, 1, 0, "t4 fifo");
        for (int i = 2; i < 18; i++) begin
            @(negedge clk);
            rx_frame(8'(i), 8, -1, 16, 16, 1, 0, "t4 fifo");
        end
        @(negedge clk);
        chk("t4 temt", {31'd0, u_if.temt_out}, 32'd1);

        // Holding-register mode: 0xA1 held, 0xB2 dropped
        u_if.fifoen_in = 1'b0;
        repeat (3) @(negedge clk);
        u_if.thr_in = 8'hC3; u_if.thr_wr_in = 1'b1;
        @(negedge clk);
        u_if.thr_wr_in = 1'b0;
        @(negedge clk);
        u_if.thr_in = 8'hA1; u_if.thr_wr_in = 1'b1;
        @(negedge clk);
        u_if.thr_in = 8'hB2;
        @(negedge clk);
        u_if.thr_wr_in = 1'b0;
        chk("t5 level held", {27'd0, u_if.tx_level_out}, 32'd1);
        chk("t5 thre held", {31'd0, u_if.thre_out}, 32'd0);
        rx_frame(8'hC3, 8, -1, 16, 16, 1, 2, "t5 hold");
        chk("t5 thre end C3", {31'd0, u_if.thre_out}, 32'd0);
        @(negedge clk);
        chk("t5 thre A1 loaded", {31'd0, u_if.thre_out}, 32'd1);
        rx_frame(8'hA1, 8, -1, 16, 16, 1, 0, "t5 hold");
        @(negedge clk);
        chk("t5 temt", {31'd0, u_if.temt_out}, 32'd1);

        // txclr with a simultaneous write: storage emptied, frame completes
        u_if.fifoen_in = 1'b1;
        repeat (3) @(negedge clk);
        u_if.thr_in = 8'h11; u_if.thr_wr_in = 1'b1;
        @(negedge clk);
        u_if.thr_in = 8'h22;
        @(negedge clk);
        u_if.thr_in = 8'h33;
        @(negedge clk);
        u_if.thr_wr_in = 1'b0;
        chk("t6 level pre-clr", {27'd0, u_if.tx_level_out}, 32'd2);
        u_if.txclr_in = 1'b1; u_if.thr_in = 8'h44; u_if.thr_wr_in = 1'b1;
        @(negedge clk);
        u_if.txclr_in = 1'b0; u_if.thr_wr_in = 1'b0;
        chk("t6 level post-clr", {27'd0, u_if.tx_level_out}, 32'd0);
        chk("t6 thre post-clr", {31'd0, u_if.thre_out}, 32'd1);
        rx_frame(8'h11, 8, -1, 16, 16, 1, 2, "t6 clr");
        @(negedge clk);
        chk("t6 temt", {31'd0, u_if.temt_out}, 32'd1);

        // Transmitter reset mid-frame
        u_if.thr_in = 8'h5A; u_if.thr_wr_in = 1'b1;
        @(negedge clk);
        u_if.thr_wr_in = 1'b0;
        @(negedge clk);
        chk("t7 start", {31'd0, txd}, 32'd0);
        repeat (18) @(negedge clk);
        u_if.thr_in = 8'h66; u_if.thr_wr_in = 1'b1;
        @(negedge clk);
        u_if.thr_wr_in = 1'b0;
        @(negedge clk);
        chk("t7 txd before", {31'd0, txd}, 32'd0);
        chk("t7 level before", {27'd0, u_if.tx_level_out}, 32'd1);
        u_if.utrst_in = 1'b0;
        @(negedge clk);
        chk("t7 txd utrst", {31'd0, txd}, 32'd1);
        chk("t7 level utrst", {27'd0, u_if.tx_level_out}, 32'd0);
        chk("t7 temt utrst", {31'd0, u_if.temt_out}, 32'd1);
        u_if.thr_in = 8'h77; u_if.thr_wr_in = 1'b1;
        @(negedge clk);
        u_if.thr_wr_in = 1'b0;
        @(negedge clk);
        u_if.utrst_in = 1'b1;
        @(negedge clk);
        chk("t7 wr dropped", {27'd0, u_if.tx_level_out}, 32'd0);
        repeat (40) @(negedge clk);
        chk("t7 line idle", {31'd0, txd}, 32'd1);
        chk("t7 temt idle", {31'd0, u_if.temt_out}, 32'd1);
        $display("[TB] t7 utrst: frame 5a aborted");

        // Break over a running frame
        u_if.thr_in = 8'h0F; u_if.thr_wr_in = 1'b1;
        @(negedge clk);
        u_if.thr_wr_in = 1'b0;
        @(negedge clk);
        chk("t8 start", {31'd0, txd}, 32'd0);
        repeat (20) @(negedge clk);
        u_if.bc_in = 1'b1;
        @(negedge clk);
        chk("t8 brk 21", {31'd0, txd}, 32'd0);
        repeat (10) @(negedge clk);
        chk("t8 brk 31", {31'd0, txd}, 32'd0);
        repeat (29) @(negedge clk);
        chk("t8 brk 60", {31'd0, txd}, 32'd0);
        repeat (40) @(negedge clk);
        chk("t8 brk 100", {31'd0, txd}, 32'd0);
        u_if.bc_in = 1'b0;
        @(negedge clk);
        rx_frame(8'h0F, 8, -1, 16, 16, 1, 101, "t8 brk");
        @(negedge clk);
        chk("t8 temt", {31'd0, u_if.temt_out}, 32'd1);

        // Asynchronous reset mid-frame
        u_if.thr_in = 8'hAA; u_if.thr_wr_in = 1'b1;
        @(negedge clk);
        u_if.thr_in = 8'hBB;
        @(negedge clk);
        u_if.thr_wr_in = 1'b0;
        repeat (4) @(negedge clk);
        chk("t9 txd pre", {31'd0, txd}, 32'd0);
        chk("t9 level pre", {27'd0, u_if.tx_level_out}, 32'd1);
        #2 rstn = 1'b0;
        #1;
        chk("t9 txd async", {31'd0, txd}, 32'd1);
        chk("t9 level async", {27'd0, u_if.tx_level_out}, 32'd0);
        chk("t9 thre async", {31'd0, u_if.thre_out}, 32'd1);
        chk("t9 temt async", {31'd0, u_if.temt_out}, 32'd1);
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
